queue_operand_reader: RTL

- Consumer-side controller for the byte-wide instruction-queue FIFO. It drives the FIFO slave signals: read_enable out; read_data and is_empty in.
- Serves operand requests from the execution unit. A request pops one byte, or two bytes in little-endian order. The block returns a zero- or sign-extended 16-bit result over a valid/ready handshake.
- Handles queue flush on control transfer and counts stall cycles caused by an empty queue.

---
 rtl/queue_operand_reader_if.sv | 55 +++++
 rtl/queue_operand_reader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/queue_operand_reader_if.sv
`default_nettype none
// =============================================================================
// queue_operand_reader_if : request/response, FIFO-read and status bundle
// Revision: 1.0
// =============================================================================
interface queue_operand_reader_if #(
    parameter int WIDTH_DATA  = 8,
    parameter int WIDTH_STALL = 8
);
    logic                      flush;
    logic                      req_valid;
    logic                      req_word;
    logic                      req_sext;
    logic                      req_ready;
    logic                      rsp_valid;
    logic [2*WIDTH_DATA-1:0]   rsp_data;
    logic                      rsp_ready;
    logic                      fifo_read_enable;
    logic [WIDTH_DATA-1:0]     fifo_read_data;
    logic                      fifo_is_empty;
    logic [WIDTH_STALL-1:0]    stall_cycles;

    // Reader side: the operand reader itself.
    modport master (
        input  flush,
        input  req_valid,
        input  req_word,
        input  req_sext,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        input  rsp_ready,
        output fifo_read_enable,
        input  fifo_read_data,
        input  fifo_is_empty,
        output stall_cycles
    );

    // Environment side: execution unit plus instruction-queue FIFO.
    modport slave (
        output flush,
        output req_valid,
        output req_word,
        output req_sext,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        output rsp_ready,
        input  fifo_read_enable,
        output fifo_read_data,
        output fifo_is_empty,
        input  stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/queue_operand_reader.sv
`default_nettype none
// =============================================================================
// queue_operand_reader : pops one or two bytes from the instruction queue and
//                        returns a zero/sign-extended operand over valid/ready
// Revision: 1.0
// =============================================================================
module queue_operand_reader #(
    parameter int WIDTH_DATA  = 8,
    parameter int WIDTH_STALL = 8
) (
    input  wire logic                clock,
    input  wire logic                reset_n,
    queue_operand_reader_if.master   bus
);

    localparam logic [WIDTH_STALL-1:0] c_stall_one = WIDTH_STALL'(1);
    localparam logic [WIDTH_STALL-1:0] c_stall_max = '1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_LO   = 3'd1,
        CAPTURE_LO = 3'd2,
        FETCH_HI   = 3'd3,
        CAPTURE_HI = 3'd4,
        RESPOND    = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic                       word_q, word_d;
    logic                       sext_q, sext_d;
    logic [2*WIDTH_DATA-1:0]    rsp_data_q, rsp_data_d;
    logic [WIDTH_STALL-1:0]     stall_cycles_q, stall_cycles_d;
    logic                       accept_ready;
    logic                       pop;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            word_q         <= 1'b0;
            sext_q         <= 1'b0;
            rsp_data_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            sext_q         <= sext_d;
            rsp_data_q     <= rsp_data_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        sext_d         = sext_q;
        rsp_data_d     = rsp_data_q;
        stall_cycles_d = stall_cycles_q;
        accept_ready   = 1'b0;
        pop            = 1'b0;

        case (state_q)
            IDLE: begin
                accept_ready = 1'b1;
                if (bus.req_valid) begin
                    word_d         = bus.req_word;
                    sext_d         = bus.req_sext;
                    stall_cycles_d = '0;
                    state_d        = FETCH_LO;
                end
            end

            FETCH_LO, FETCH_HI: begin
                if (!bus.fifo_is_empty) begin
                    pop     = 1'b1;
                    state_d = (state_q == FETCH_LO) ? CAPTURE_LO : CAPTURE_HI;
                end else if (stall_cycles_q != c_stall_max) begin
                    stall_cycles_d = stall_cycles_q + c_stall_one;
                end
            end

            CAPTURE_LO: begin
                rsp_data_d[WIDTH_DATA-1:0] = bus.fifo_read_data;
                if (word_q) begin
                    state_d = FETCH_HI;
                end else begin
                    rsp_data_d[2*WIDTH_DATA-1:WIDTH_DATA] =
                        sext_q ? {WIDTH_DATA{bus.fifo_read_data[WIDTH_DATA-1]}} : '0;
                    state_d = RESPOND;
                end
            end

            CAPTURE_HI: begin
                rsp_data_d[2*WIDTH_DATA-1:WIDTH_DATA] = bus.fifo_read_data;
                state_d = RESPOND;
            end

            RESPOND: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush abandons whatever is in flight; a byte already popped is dropped
        // uncaptured and the stall count is frozen for inspection.
        if (bus.flush) begin
            state_d        = IDLE;
            word_d         = word_q;
            sext_d         = sext_q;
            rsp_data_d     = rsp_data_q;
            stall_cycles_d = stall_cycles_q;
            accept_ready   = 1'b0;
            pop            = 1'b0;
        end
    end

    assign bus.req_ready        = accept_ready;
    assign bus.fifo_read_enable = pop;
    assign bus.rsp_valid        = (state_q == RESPOND);
    assign bus.rsp_data         = rsp_data_q;
    assign bus.stall_cycles     = stall_cycles_q;

endmodule
`default_nettype wire
